// File: rtl/idct_pkg.sv
// Shared types and constants for the 8x8 IDCT engine:
// basis table B[k][n], default widths and the FSM state enum.
package idct_pkg;

  localparam int COEF_W_DEF = 12;
  localparam int MID_W_DEF  = 16;
  localparam int BASIS_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROW,
    S_COL,
    S_OUT
  } state_e;

  // B[k][n] stored at index k*8+n
  localparam int BASIS_TBL [64] = '{
     91,   91,   91,   91,   91,   91,   91,   91,
    126,  106,   71,   25,  -25,  -71, -106, -126,
    118,   49,  -49, -118, -118,  -49,   49,  118,
    106,  -25, -126,  -71,   71,  126,   25, -106,
     91,  -91,  -91,   91,   91,  -91,  -91,   91,
     71, -126,   25,  106, -106,  -25,  126,  -71,
     49, -118,  118,  -49,  -49,  118, -118,   49,
     25,  -71,  106, -126,  126, -106,   71,  -25
  };

endpackage

// File: rtl/idct_8x8_engine_lut.sv
// Combinational basis lookup shared by the row and column passes.
// Ports: k_i/n_i select B[k][n]; b_o is the signed basis value.
module idct_basis_lut
  import idct_pkg::*;
(
  input  logic [2:0]                k_i,
  input  logic [2:0]                n_i,
  output logic signed [BASIS_W-1:0] b_o
);

  assign b_o = BASIS_W'(BASIS_TBL[{k_i, n_i}]);

endmodule

// File: rtl/idct_8x8_engine.sv
// 8x8 separable IDCT: loads 64 coefficients, runs a 512-cycle row
// pass and a 512-cycle column pass on one shared MAC, then streams
// 64 pixels. Ports: coef_* valid/ready input stream, pix_* output
// stream, busy (not IDLE), blk_err (framing-error pulse).
// Option: define IDCT_LEVEL_SHIFT_EN for 0..255 level-shifted pixels.
module idct_8x8_engine
  import idct_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF,
  parameter int MID_W  = MID_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_last,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [8:0]        pix_data,
  output logic              pix_last,
  output logic              busy,
  output logic              blk_err
);

  localparam int OP_W  = (COEF_W > MID_W) ? COEF_W : MID_W;
  localparam int ACC_W = OP_W + BASIS_W + 3;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t RND     = acc_t'(128);
  localparam acc_t MID_MAX = acc_t'(2 ** (MID_W - 1) - 1);
  localparam acc_t MID_MIN = acc_t'(-(2 ** (MID_W - 1)));
  localparam acc_t PIX_HI  = acc_t'(255);
`ifdef IDCT_LEVEL_SHIFT_EN
  localparam acc_t PIX_LO  = acc_t'(0);
`else
  localparam acc_t PIX_LO  = acc_t'(-256);
`endif

  state_e state_q, state_d;

  logic [5:0] lcnt_q;
  logic [5:0] ocnt_q;
  logic [8:0] cnt_q;
  acc_t       acc_q;
  logic       err_q;

  logic signed [COEF_W-1:0] xbuf_q [64];
  logic signed [MID_W-1:0]  tbuf_q [64];
  logic [8:0]               pbuf_q [64];

  logic coef_fire;
  logic pix_fire;
  logic load_done;
  logic in_row;
  logic in_col;
  logic mac_last;
  logic pass_end;

  logic [2:0]                lut_n;
  logic signed [BASIS_W-1:0] basis;
  logic signed [OP_W-1:0]    opnd;

  acc_t prod;
  acc_t sum;
  acc_t shr;
  acc_t pix_v;

  logic signed [MID_W-1:0] t_sat;
  logic [8:0]              pix_sat;

  assign in_row   = (state_q == S_ROW);
  assign in_col   = (state_q == S_COL);
  assign busy     = (state_q != S_IDLE);

  assign coef_ready = rst_n &
    ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign coef_fire  = coef_valid & coef_ready;
  assign load_done  = coef_fire &
    (coef_last | (lcnt_q == 6'd63));

  assign pix_valid = (state_q == S_OUT);
  assign pix_fire  = pix_valid & pix_ready;
  assign pix_last  = pix_valid & (ocnt_q == 6'd63);
  assign pix_data  = pix_valid ? pbuf_q[ocnt_q] : '0;
  assign blk_err   = err_q;

  // cnt = {out_hi, out_lo, k}: row pass walks (k1,n2,k2),
  // column pass walks (n1,n2,k1); both emit in row-major order.
  assign mac_last = (cnt_q[2:0] == 3'd7);
  assign pass_end = (cnt_q == 9'd511);
  assign lut_n    = in_col ? cnt_q[8:6] : cnt_q[5:3];

  idct_basis_lut u_lut (
    .k_i (cnt_q[2:0]),
    .n_i (lut_n),
    .b_o (basis)
  );

  assign opnd = in_row
    ? OP_W'(xbuf_q[{cnt_q[8:6], cnt_q[2:0]}])
    : OP_W'(tbuf_q[{cnt_q[2:0], cnt_q[5:3]}]);

  // The eighth product is folded in combinationally so each
  // output completes in exactly eight cycles.
  assign prod = acc_t'(basis) * acc_t'(opnd);
  assign sum  = acc_q + prod + RND;
  assign shr  = sum >>> 8;

  always_comb begin
    t_sat = shr[MID_W-1:0];
    if (shr > MID_MAX) begin
      t_sat = MID_MAX[MID_W-1:0];
    end else if (shr < MID_MIN) begin
      t_sat = MID_MIN[MID_W-1:0];
    end
  end

`ifdef IDCT_LEVEL_SHIFT_EN
  assign pix_v = shr + RND;
`else
  assign pix_v = shr;
`endif

  always_comb begin
    pix_sat = pix_v[8:0];
    if (pix_v > PIX_HI) begin
      pix_sat = PIX_HI[8:0];
    end else if (pix_v < PIX_LO) begin
      pix_sat = PIX_LO[8:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (coef_fire) begin
        state_d = load_done ? S_ROW : S_LOAD;
      end
      S_LOAD: if (load_done) state_d = S_ROW;
      S_ROW:  if (pass_end) state_d = S_COL;
      S_COL:  if (pass_end) state_d = S_OUT;
      S_OUT:  if (pix_last & pix_ready) begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      ocnt_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      // framing error: last early, or 64th word without last
      err_q <= coef_fire &
        (coef_last ^ (lcnt_q == 6'd63));
      if (coef_fire) begin
        lcnt_q <= load_done ? 6'd0 : lcnt_q + 6'd1;
      end
      if (in_row | in_col) begin
        cnt_q <= cnt_q + 9'd1;
        acc_q <= mac_last ? '0 : acc_q + prod;
      end else begin
        cnt_q <= '0;
        acc_q <= '0;
      end
      if (pix_fire) ocnt_q <= ocnt_q + 6'd1;
    end
  end

  // Cleared once the row pass has consumed it, so a short block
  // loads into an all-zero buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) xbuf_q[i] <= '0;
    end else if (in_row & pass_end) begin
      for (int i = 0; i < 64; i++) xbuf_q[i] <= '0;
    end else if (coef_fire) begin
      xbuf_q[lcnt_q] <= $signed(coef_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) tbuf_q[i] <= '0;
    end else if (in_row & mac_last) begin
      tbuf_q[cnt_q[8:3]] <= t_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) pbuf_q[i] <= '0;
    end else if (in_col & mac_last) begin
      pbuf_q[cnt_q[8:3]] <= pix_sat;
    end
  end

endmodule

// File: doc/idct_8x8_engine.md
IDCT_8X8_ENGINE -- requirements
Module: idct_8x8_engine

Interface
REQ-001 SHALL have parameter COEF_W, default 12, signed DCT coefficient width.
REQ-002 SHALL have parameter MID_W, default 16, signed intermediate (row-pass result) width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port coef_valid  input  1  coefficient word valid.
REQ-006 SHALL have port coef_ready  output  1  engine accepts coefficient.
REQ-007 SHALL have port coef_data  input  COEF_W  coefficient X[k1][k2], row-major (k1 outer, k2 inner).
REQ-008 SHALL have port coef_last  input  1  marks final coefficient of block.
REQ-009 SHALL have port pix_valid  output  1  pixel word valid.
REQ-010 SHALL have port pix_ready  input  1  downstream accepts pixel.
REQ-011 SHALL have port pix_data  output  9  signed pixel x[n1][n2], row-major.
REQ-012 SHALL have port pix_last  output  1  asserted with 64th pixel.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port blk_err  output  1  one-cycle pulse on framing error.

Function
REQ-015 SHALL implement FSM IDLE->LOAD->ROW->COL->OUT->IDLE; first accepted coefficient moves IDLE->LOAD.
REQ-016 SHALL assert coef_ready only in IDLE and LOAD; a transfer occurs when coef_valid and coef_ready are both high.
REQ-017 SHALL use basis B[k][n] = round(256*(C(k)/2)*cos((2n+1)k*pi/16)), C(0)=1/sqrt2, else 1, signed 10-bit; B[0][n]=91.
REQ-018 Row pass SHALL compute T[k1][n2] = (sum_k2 B[k2][n2]*X[k1][k2] + 128) >>> 8, saturated to MID_W; one MAC per cycle, 512 cycles.
REQ-019 Column pass SHALL compute Y[n1][n2] = (sum_k1 B[k1][n1]*T[k1][n2] + 128) >>> 8; one MAC per cycle, 512 cycles.
REQ-020 Accumulator SHALL be wide enough that no intermediate overflow occurs (>= COEF_W+10+3 row, MID_W+10+3 column).
REQ-021 Coefficient-to-first-pixel latency SHALL be exactly 1024 cycles after the cycle that accepts the 64th coefficient (or early last).
REQ-022 OUT SHALL present 64 pixels in order; pix_data/pix_last SHALL hold stable while pix_valid and not pix_ready.
REQ-023 OUT->IDLE SHALL occur on the cycle pix_last transfers; coef_ready rises the following cycle.
REQ-024 Early coef_last (count < 64) SHALL zero-fill remaining coefficients, pulse blk_err, and proceed to ROW.
REQ-025 Missing coef_last on 64th coefficient SHALL still proceed to ROW and pulse blk_err.
REQ-026 Input buffer and transpose buffer SHALL be separate 64-entry registers/RAMs; no overlap of load with compute.

Reset
REQ-027 rst_n low SHALL force IDLE, coef_ready=0 during reset and 1 the first cycle after, pix_valid=0, pix_last=0, pix_data=0, busy=0, blk_err=0, counters=0.
REQ-028 Reset mid-block SHALL discard all partial data; no pixel of that block SHALL appear.

Configuration
REQ-029 Macro IDCT_LEVEL_SHIFT_EN defined: pix_data = clamp(Y+128, 0, 255), zero-extended to 9 bits.
REQ-030 IDCT_LEVEL_SHIFT_EN undefined: pix_data = clamp(Y, -256, 255) signed.

Structure
REQ-031 Package idct_pkg SHALL hold the 8x8 basis table B, COEF_W/MID_W defaults, basis width, and the FSM state enum.
REQ-032 Sub-module idct_basis_lut SHALL be the single combinational lookup (k, n -> B[k][n]), shared by both passes.

Verification (level shift enabled unless stated)
REQ-033 All-zero block -> 64 pixels = 128, pix_last on 64th, blk_err never pulses.
REQ-034 X[0][0]=64, rest 0 -> T row0 = 23, all pixels = 136; first pix_valid exactly 1024 cycles after last coefficient.
REQ-035 X[0][0]=2047 -> all pixels 255 (Y=259); X[0][0]=-2048 -> all 0 (Y=-259); macro off -> 255 and -256.
REQ-036 coef_last on 10th coefficient -> blk_err pulse, output matches golden model with X[10..63]=0.
REQ-037 Random pix_ready backpressure (50%) over 3 random blocks -> bit-exact vs golden model, data stable while stalled.
REQ-038 rst_n asserted during COL -> outputs at reset values; next block outputs bit-exact, no stale pixels.
